// File: rtl/grf_mport_sb.sv
// General register file: NRD write-through bypassed read ports, two write ports
// (port 1 wins on conflict), and a per-register pending-write scoreboard.
module grf_mport_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 3,
  parameter int CW   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a,
  output logic                sb_ovf,
  output logic                sb_unf
);

  localparam int NREG = 2**AW;
  localparam logic [CW+1:0] CMAX = (CW+2)'(2**CW - 1);

  logic [XLEN-1:0] regs    [NREG];
  logic [CW-1:0]   cnt     [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [1:0]      dec     [NREG];
  logic            act0, act1;
  logic            ovf_hit, unf_hit;

  always_comb begin
    act0 = we0 && (wa0 != '0);
    act1 = we1 && (wa1 != '0);
  end

  // Counter update evaluated in CW+2 bits; bit CW+1 flags a negative result.
  always_comb begin
    logic          inc;
    logic [CW+1:0] sum;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      dec[r] = {1'b0, act0 && (wa0 == AW'(r))} + {1'b0, act1 && (wa1 == AW'(r))};
      inc    = rsv_en && (rsv_a == AW'(r)) && (r != 0);
      sum    = {2'b00, cnt[r]} + (CW+2)'(inc);
      if (sum > CMAX) begin
        sum     = {2'b00, cnt[r]};
        ovf_hit = 1'b1;
      end
      sum = sum - {{CW{1'b0}}, dec[r]};
      if (sum[CW+1]) begin
        cnt_nxt[r] = '0;
        unf_hit    = 1'b1;
      end else begin
        cnt_nxt[r] = sum[CW-1:0];
      end
      if (r == 0) cnt_nxt[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_ovf <= 1'b0;
      sb_unf <= 1'b0;
    end else begin
      if (act0) regs[wa0] <= wd0;
      if (act1) regs[wa1] <= wd1;
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (ovf_hit) sb_ovf <= 1'b1;
      if (unf_hit) sb_unf <= 1'b1;
    end
  end

  // Busy sees same-cycle releases (matching the data bypass) but not reserves.
  always_comb begin
    logic [AW-1:0] a;
    rd   = '0;
    busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = ra[k*AW +: AW];
      if (a == '0)                   rd[k*XLEN +: XLEN] = '0;
      else if (act1 && (wa1 == a))   rd[k*XLEN +: XLEN] = wd1;
      else if (act0 && (wa0 == a))   rd[k*XLEN +: XLEN] = wd0;
      else                           rd[k*XLEN +: XLEN] = regs[a];
      busy[k] = (a != '0) && ({2'b00, cnt[a]} > {{CW{1'b0}}, dec[a]});
    end
  end

endmodule

// File: tb/tb_grf_mport_sb.sv
// Directed-vector bench for grf_mport_sb with hand-computed expectations.
module tb_grf_mport_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;
  localparam int CW   = 2;

  logic                clk;
  logic                rst;
  logic                we0, we1;
  logic [AW-1:0]       wa0, wa1;
  logic [XLEN-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_a;
  logic                sb_ovf, sb_unf;

  int nvec = 0;
  int nerr = 0;

  grf_mport_sb #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .busy(busy),
    .rsv_en(rsv_en), .rsv_a(rsv_a),
    .sb_ovf(sb_ovf), .sb_unf(sb_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    rsv_en = 1'b0; rsv_a = '0;
  endtask

  task automatic setra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rdp(input int k);
    return rd[k*XLEN +: XLEN];
  endfunction

  initial begin
    idle();
    ra  = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(sb_ovf), 32'h0);
    check("rst_unf", 32'(sb_unf), 32'h0);

    // Fill every register, then saturate reg 4 and check state before reset.
    for (int r = 1; r < 32; r++) begin
      we0 = 1'b1; wa0 = AW'(r); wd0 = 32'(r) * 32'h01010101;
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rsv_en = 1'b1; rsv_a = 5'd4;
      tick();
    end
    idle();
    setra(0, 5'd1); setra(1, 5'd17); setra(2, 5'd4);
    #1;
    check("fill_r1", rdp(0), 32'h01010101);
    check("fill_r17", rdp(1), 32'h11111111);
    check("fill_busy4", 32'(busy[2]), 32'h1);
    check("fill_ovf", 32'(sb_ovf), 32'h1);
    check("fill_unf", 32'(sb_unf), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      setra(0, AW'(r));
      #1;
      check($sformatf("clr_r%0d", r), rdp(0), 32'h0);
    end
    setra(2, 5'd4);
    #1;
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_ovf", 32'(sb_ovf), 32'h0);
    check("clr_unf", 32'(sb_unf), 32'h0);

    // Register 0: writes and reserves are ignored.
    ra = '0;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_a = 5'd0;
    #1;
    check("z_rd_same", rdp(0), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1;
    check("z_rd_next", rdp(0), 32'h0);
    check("z_busy", 32'(busy), 32'h0);
    check("z_ovf", 32'(sb_ovf), 32'h0);
    check("z_unf", 32'(sb_unf), 32'h0);

    // Bypass of port 0.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    setra(0, 5'd5); setra(1, 5'd5);
    #1;
    check("byp_same0", rdp(0), 32'hDEADBEEF);
    check("byp_same1", rdp(1), 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("byp_next", rdp(0), 32'hDEADBEEF);

    // Dual-port conflict on reg 7: port 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    setra(2, 5'd7);
    #1;
    check("dual_same", rdp(2), 32'h22);
    tick();
    idle();
    #1;
    check("dual_next", rdp(2), 32'h22);
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h33;
    #1;
    check("byp_over_reg", rdp(2), 32'h33);
    idle();
    #1;
    check("reg_after_drop", rdp(2), 32'h22);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Scoreboard saturation on reg 3.
    ra = '0;
    setra(0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      rsv_en = 1'b1; rsv_a = 5'd3;
      #1;
      check($sformatf("sb_busy_rsv%0d", i), 32'(busy[0]), (i > 0) ? 32'h1 : 32'h0);
      check($sformatf("sb_ovf_pre%0d", i), 32'(sb_ovf), 32'h0);
      tick();
    end
    idle();
    #1;
    check("sb_busy_sat", 32'(busy[0]), 32'h1);
    check("sb_ovf_set", 32'(sb_ovf), 32'h1);
    for (int j = 0; j < 3; j++) begin
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h100 + 32'(j);
      #1;
      check($sformatf("sb_busy_wr%0d", j), 32'(busy[0]), (j < 2) ? 32'h1 : 32'h0);
      check($sformatf("sb_rd_wr%0d", j), rdp(0), 32'h100 + 32'(j));
      tick();
    end
    idle();
    #1;
    check("sb_busy_drain", 32'(busy[0]), 32'h0);
    check("sb_unf_pre", 32'(sb_unf), 32'h0);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1FF;
    tick();
    idle();
    #1;
    check("sb_unf_set", 32'(sb_unf), 32'h1);
    check("sb_ovf_sticky", 32'(sb_ovf), 32'h1);
    check("sb_rd_last", rdp(0), 32'h1FF);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Simultaneous reserve and release on reg 9 with cnt=1.
    ra = '0;
    setra(1, 5'd9);
    rsv_en = 1'b1; rsv_a = 5'd9;
    tick();
    idle();
    #1;
    check("sim_busy_pre", 32'(busy[1]), 32'h1);
    rsv_en = 1'b1; rsv_a = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    #1;
    check("sim_busy_same", 32'(busy[1]), 32'h0);
    tick();
    idle();
    #1;
    check("sim_busy_next", 32'(busy[1]), 32'h1);
    check("sim_rd", rdp(1), 32'h99);
    rst = 1'b1;
    rsv_en = 1'b1; rsv_a = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("sim_rst_busy", 32'(busy[1]), 32'h0);
    check("sim_rst_rd", rdp(1), 32'h0);
    tick();
    check("sim_rst_busy2", 32'(busy[1]), 32'h0);

    // Double release of reg 12 with cnt=2 via both ports.
    setra(2, 5'd12);
    for (int i = 0; i < 2; i++) begin
      rsv_en = 1'b1; rsv_a = 5'd12;
      tick();
    end
    idle();
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hA0;
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'hA1;
    #1;
    check("dd_busy_same", 32'(busy[2]), 32'h0);
    tick();
    idle();
    #1;
    check("dd_busy_next", 32'(busy[2]), 32'h0);
    check("dd_unf", 32'(sb_unf), 32'h0);
    check("dd_rd", rdp(2), 32'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
